mem_prog_arbiter: RTL and testbench

MEM_PROG_ARBITER -- requirements
Module: mem_prog_arbiter

---
 rtl/mem_prog_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_prog_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_prog_arbiter.sv
// Arbitrates a 16x8 RAM between the CPU and an external programmer.
// The CPU is frozen at an instruction boundary while the programmer writes.
module mem_prog_arbiter (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] cpu_addr,
  input  logic       cpu_CE_bar,
  input  logic       cpu_t1,
  output logic [7:0] cpu_rdata,
  output logic       cpu_hold,
  input  logic       prog_req,
  input  logic       prog_we,
  input  logic       prog_auto,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       prog_grant,
  output logic       prog_ack,
  output logic [3:0] prog_cur_addr,
  output logic [4:0] write_count,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [2:0] {
    CPU_OWN,
    HOLD_WAIT,
    PROG_OWN,
    WRITE,
    RELEASE
  } state_t;

  state_t     state;
  logic [3:0] ptr;
  logic       we_prev;
  logic       we_rise;
  logic [3:0] sel_addr;
  logic       prog_path;
  logic       cpu_path;

  always_comb begin
    sel_addr  = prog_auto ? ptr : prog_addr;
    we_rise   = prog_we & ~we_prev;
    cpu_path  = (state == CPU_OWN) ||
                (state == HOLD_WAIT);
    // Reset hands the address bus straight back to the CPU.
    prog_path = !CLR && !cpu_path;
  end

  always_comb begin
    prog_cur_addr = sel_addr;
    mem_wdata     = prog_data;
    mem_we        = !CLR && (state == WRITE);
    mem_addr      = cpu_addr;
    cpu_rdata     = 8'h00;
    unique case (1'b1)
      prog_path: mem_addr = sel_addr;
      default:   mem_addr = cpu_addr;
    endcase
    if (cpu_path && !cpu_CE_bar)
      cpu_rdata = mem_rdata;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state       <= CPU_OWN;
      ptr         <= 4'd0;
      write_count <= 5'd0;
      we_prev     <= 1'b0;
      prog_ack    <= 1'b0;
      cpu_hold    <= 1'b0;
      prog_grant  <= 1'b0;
    end else begin
      we_prev  <= prog_we;
      prog_ack <= 1'b0;
      unique case (state)
        CPU_OWN: begin
          if (prog_req)
            state <= HOLD_WAIT;
        end
        HOLD_WAIT: begin
          if (!prog_req) begin
            state <= CPU_OWN;
          end else if (cpu_t1) begin
            state       <= PROG_OWN;
            cpu_hold    <= 1'b1;
            prog_grant  <= 1'b1;
            ptr         <= prog_addr;
            write_count <= 5'd0;
          end
        end
        PROG_OWN: begin
          // Release has priority over a coincident write edge.
          if (!prog_req) begin
            state      <= RELEASE;
            prog_grant <= 1'b0;
          end else if (we_rise) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          state    <= PROG_OWN;
          prog_ack <= 1'b1;
          if (write_count != 5'd16)
            write_count <= write_count + 5'd1;
          if (prog_auto)
            ptr <= ptr + 4'd1;
        end
        RELEASE: begin
          state    <= CPU_OWN;
          cpu_hold <= 1'b0;
        end
        default: begin
          state      <= CPU_OWN;
          cpu_hold   <= 1'b0;
          prog_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_prog_arbiter.sv
// Bench for mem_prog_arbiter: table of CPU-side cycles plus
// hand sequences for programmer writes, release and reset.
module tb_mem_prog_arbiter;

  logic       CLK;
  logic       CLR;
  logic [3:0] cpu_addr;
  logic       cpu_CE_bar;
  logic       cpu_t1;
  logic [7:0] cpu_rdata;
  logic       cpu_hold;
  logic       prog_req;
  logic       prog_we;
  logic       prog_auto;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       prog_grant;
  logic       prog_ack;
  logic [3:0] prog_cur_addr;
  logic [4:0] write_count;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  logic [7:0] ram [16];

  int checks = 0;
  int errors = 0;

  mem_prog_arbiter dut (
    .CLK(CLK),
    .CLR(CLR),
    .cpu_addr(cpu_addr),
    .cpu_CE_bar(cpu_CE_bar),
    .cpu_t1(cpu_t1),
    .cpu_rdata(cpu_rdata),
    .cpu_hold(cpu_hold),
    .prog_req(prog_req),
    .prog_we(prog_we),
    .prog_auto(prog_auto),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .prog_grant(prog_grant),
    .prog_ack(prog_ack),
    .prog_cur_addr(prog_cur_addr),
    .write_count(write_count),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_rdata = ram[mem_addr];

  always @(posedge CLK)
    if (mem_we === 1'b1)
      ram[mem_addr] <= mem_wdata;

  typedef struct {
    logic       req;
    logic       t1;
    logic       ce_bar;
    logic [3:0] addr;
    logic       hold;
    logic       grant;
    logic [7:0] rdata;
    logic       chk_ma;
    logic [3:0] ma;
  } vec_t;

  vec_t vec [15];

  function automatic vec_t mk(
    input logic req, input logic t1,
    input logic ce_bar, input logic [3:0] addr,
    input logic hold, input logic grant,
    input logic [7:0] rdata,
    input logic chk_ma, input logic [3:0] ma);
    vec_t v;
    v.req = req; v.t1 = t1;
    v.ce_bar = ce_bar; v.addr = addr;
    v.hold = hold; v.grant = grant;
    v.rdata = rdata;
    v.chk_ma = chk_ma; v.ma = ma;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic do_grant();
    prog_req = 1'b1;
    cpu_t1   = 1'b1;
    tick();
    tick();
    cpu_t1 = 1'b0;
    mid();
    chk("grant_hold", cpu_hold, 1);
    chk("grant_grant", prog_grant, 1);
    chk("grant_wc", write_count, 0);
  endtask

  task automatic pulse(input logic [7:0] d,
                       input logic [3:0] ea,
                       input logic [4:0] ewc);
    prog_data = d;
    prog_we   = 1'b1;
    tick();
    prog_we = 1'b0;
    mid();
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, ea);
    chk("wr_data", mem_wdata, d);
    tick();
    mid();
    chk("wr_ack", prog_ack, 1);
    chk("wr_count", write_count, ewc);
    tick();
  endtask

  task automatic do_release();
    prog_req = 1'b0;
    tick();
    mid();
    chk("rel_grant", prog_grant, 0);
    chk("rel_hold", cpu_hold, 1);
    chk("rel_we", mem_we, 0);
    tick();
    mid();
    chk("rel_done_hold", cpu_hold, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++)
      ram[i] = 8'h10 + 8'(i);

    CLR        = 1'b1;
    cpu_addr   = 4'h5;
    cpu_CE_bar = 1'b0;
    cpu_t1     = 1'b0;
    prog_req   = 1'b0;
    prog_we    = 1'b0;
    prog_auto  = 1'b0;
    prog_addr  = 4'h9;
    prog_data  = 8'h00;

    tick();
    tick();
    mid();
    chk("rst_hold", cpu_hold, 0);
    chk("rst_grant", prog_grant, 0);
    chk("rst_ack", prog_ack, 0);
    chk("rst_wc", write_count, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_maddr", mem_addr, 4'h5);
    chk("rst_rdata", cpu_rdata, 8'h15);
    tick();
    CLR = 1'b0;

    vec[0]  = mk(0, 0, 0, 4'h5, 0, 0, 8'h15, 1, 4'h5);
    vec[1]  = mk(0, 0, 1, 4'h6, 0, 0, 8'h00, 1, 4'h6);
    vec[2]  = mk(1, 0, 0, 4'h2, 0, 0, 8'h12, 1, 4'h2);
    vec[3]  = mk(1, 0, 0, 4'h3, 0, 0, 8'h13, 1, 4'h3);
    vec[4]  = mk(1, 0, 0, 4'h3, 0, 0, 8'h13, 1, 4'h3);
    vec[5]  = mk(1, 0, 0, 4'h3, 0, 0, 8'h13, 1, 4'h3);
    vec[6]  = mk(1, 0, 0, 4'h3, 0, 0, 8'h13, 1, 4'h3);
    vec[7]  = mk(1, 1, 0, 4'h4, 0, 0, 8'h14, 1, 4'h4);
    vec[8]  = mk(1, 0, 0, 4'h4, 1, 1, 8'h00, 1, 4'h9);
    vec[9]  = mk(0, 0, 0, 4'h4, 1, 1, 8'h00, 1, 4'h9);
    vec[10] = mk(0, 0, 0, 4'h4, 1, 0, 8'h00, 0, 4'h0);
    vec[11] = mk(0, 0, 0, 4'h7, 0, 0, 8'h17, 1, 4'h7);
    vec[12] = mk(1, 0, 0, 4'h8, 0, 0, 8'h18, 1, 4'h8);
    vec[13] = mk(0, 0, 0, 4'h8, 0, 0, 8'h18, 1, 4'h8);
    vec[14] = mk(0, 0, 1, 4'h8, 0, 0, 8'h00, 1, 4'h8);

    for (int i = 0; i < 15; i++) begin
      prog_req   = vec[i].req;
      cpu_t1     = vec[i].t1;
      cpu_CE_bar = vec[i].ce_bar;
      cpu_addr   = vec[i].addr;
      mid();
      chk($sformatf("v%0d_hold", i), cpu_hold, vec[i].hold);
      chk($sformatf("v%0d_grant", i), prog_grant, vec[i].grant);
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vec[i].rdata);
      chk($sformatf("v%0d_we", i), mem_we, 0);
      chk($sformatf("v%0d_ack", i), prog_ack, 0);
      if (vec[i].chk_ma)
        chk($sformatf("v%0d_maddr", i), mem_addr, vec[i].ma);
      tick();
    end

    cpu_t1     = 1'b0;
    cpu_CE_bar = 1'b1;

    // auto-increment with wrap from 15 to 0
    prog_auto = 1'b1;
    prog_addr = 4'hE;
    do_grant();
    pulse(8'hA1, 4'hE, 5'd1);
    pulse(8'hA2, 4'hF, 5'd2);
    pulse(8'hA3, 4'h0, 5'd3);
    chk("auto_ram14", ram[14], 8'hA1);
    chk("auto_ram15", ram[15], 8'hA2);
    chk("auto_ram0", ram[0], 8'hA3);
    chk("auto_cur", prog_cur_addr, 4'h1);
    do_release();
    chk("auto_wc_held", write_count, 3);

    // level-held write strobe gives one write
    prog_auto = 1'b0;
    prog_addr = 4'h3;
    prog_data = 8'h5C;
    do_grant();
    prog_we = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      mid();
      if (mem_we === 1'b1)
        n++;
    end
    prog_we = 1'b0;
    tick();
    chk("held_we_pulses", n, 1);
    chk("held_ram3", ram[3], 8'h5C);
    chk("held_wc", write_count, 1);
    do_release();

    // release beats a coincident write edge
    do_grant();
    prog_data = 8'h77;
    prog_req  = 1'b0;
    prog_we   = 1'b1;
    tick();
    mid();
    chk("race_we", mem_we, 0);
    chk("race_grant", prog_grant, 0);
    chk("race_hold", cpu_hold, 1);
    tick();
    mid();
    chk("race_we2", mem_we, 0);
    chk("race_hold2", cpu_hold, 0);
    chk("race_ram3", ram[3], 8'h5C);
    prog_we = 1'b0;
    tick();

    // reset in the middle of a write
    prog_addr = 4'h7;
    do_grant();
    pulse(8'h66, 4'h7, 5'd1);
    prog_data = 8'h99;
    prog_we   = 1'b1;
    tick();
    CLR     = 1'b1;
    prog_we = 1'b0;
    tick();
    CLR        = 1'b0;
    prog_req   = 1'b0;
    cpu_CE_bar = 1'b0;
    cpu_addr   = 4'h5;
    mid();
    chk("clr_we", mem_we, 0);
    chk("clr_ack", prog_ack, 0);
    chk("clr_wc", write_count, 0);
    chk("clr_hold", cpu_hold, 0);
    chk("clr_grant", prog_grant, 0);
    chk("clr_rdata", cpu_rdata, 8'h15);
    tick();
    mid();
    chk("clr_ack2", prog_ack, 0);
    tick();
    cpu_CE_bar = 1'b1;

    // seventeen writes saturate the counter
    prog_auto = 1'b1;
    prog_addr = 4'h0;
    do_grant();
    for (int i = 0; i < 17; i++)
      pulse(8'h40 + 8'(i), 4'(i), (i >= 15) ? 5'd16 : 5'(i + 1));
    chk("sat_wc", write_count, 16);
    chk("sat_ram0", ram[0], 8'h50);
    chk("sat_ram1", ram[1], 8'h41);
    cpu_CE_bar = 1'b0;
    cpu_addr   = 4'h5;
    mid();
    chk("hold_rdata", cpu_rdata, 8'h00);
    chk("hold_maddr", mem_addr, 4'h1);
    tick();
    do_release();
    mid();
    chk("post_rdata", cpu_rdata, 8'h45);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
